// File: rtl/enc_pkg.sv
// Shared types and helpers for the multi-turn encoder tracker.
package enc_pkg;

  localparam int ST_W_DEF   = 17;
  localparam int TURN_W_DEF = 16;
  localparam int SEXT_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Sign-extends the low w bits of v to SEXT_W bits; callers size-cast the result to AP_W.
  function automatic logic [SEXT_W-1:0] sext_step(input logic [SEXT_W-1:0] v, input int w);
    logic signed [SEXT_W-1:0] t;
    t = $signed(v << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/enc_step.sv
// Wrap-aware step between two single-turn positions plus the plausibility compare.
module enc_step
  import enc_pkg::*;
#(
  parameter int ST_W     = ST_W_DEF,
  parameter int MAX_STEP = 1024
) (
  input  logic [ST_W-1:0] i_pos,
  input  logic [ST_W-1:0] i_last_pos,
  output logic [ST_W-1:0] o_step,
  output logic            o_accept
);

  logic [ST_W-1:0] w_diff;
  logic [ST_W-1:0] w_mag;
  logic            w_most_neg;

  assign w_diff = i_pos - i_last_pos;
  assign w_mag  = w_diff[ST_W-1] ? -w_diff : w_diff;

  // The most negative step has no positive magnitude in ST_W bits, so reject it explicitly.
  assign w_most_neg = (w_diff == {1'b1, {(ST_W-1){1'b0}}});

  assign o_step   = w_diff;
  assign o_accept = !w_most_neg && (w_mag <= ST_W'(MAX_STEP));

endmodule

// File: rtl/enc_track.sv
// Multi-turn position tracker: accumulates wrap-aware steps into an extended absolute position.
// Optional windowed velocity sum is built when ENC_TRACK_VEL_EN is defined.
module enc_track
  import enc_pkg::*;
#(
  parameter int ST_W     = ST_W_DEF,
  parameter int TURN_W   = TURN_W_DEF,
  parameter int MAX_STEP = 1024,
  parameter int MAX_ERR  = 3,
  parameter int AVG_LOG  = 2,
  localparam int AP_W    = TURN_W + ST_W,
  localparam int VEL_W   = ST_W + AVG_LOG
) (
  input  logic             enc_clk,
  input  logic             rst,
  input  logic             pos_vld,
  input  logic [ST_W-1:0]  pos_in,
  input  logic             clr,
  output logic [AP_W-1:0]  abs_pos,
  output logic             abs_vld,
  output logic [ST_W-1:0]  delta,
  output logic             jump_err,
  output logic             fault
`ifdef ENC_TRACK_VEL_EN
  ,
  output logic [VEL_W-1:0] vel,
  output logic             vel_vld
`endif
);

  state_t          r_state;
  logic [ST_W-1:0] r_last_pos;
  logic [3:0]      r_err_cnt;
  logic [AP_W-1:0] r_abs_pos;
  logic            r_abs_vld;
  logic [ST_W-1:0] r_delta;
  logic            r_jump_err;
  logic            r_fault;

  logic [ST_W-1:0] w_step;
  logic            w_accept;

  enc_step #(
    .ST_W     (ST_W),
    .MAX_STEP (MAX_STEP)
  ) u_step (
    .i_pos      (pos_in),
    .i_last_pos (r_last_pos),
    .o_step     (w_step),
    .o_accept   (w_accept)
  );

`ifdef ENC_TRACK_VEL_EN
  logic [AVG_LOG-1:0] r_win_cnt;
  logic [VEL_W-1:0]   r_vel_acc;
  logic [VEL_W-1:0]   r_vel;
  logic               r_vel_vld;
`endif

  // clr dominates a coincident frame; FAULT ignores frames until clr.
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_pos <= '0;
      r_err_cnt  <= '0;
      r_abs_pos  <= '0;
      r_abs_vld  <= 1'b0;
      r_delta    <= '0;
      r_jump_err <= 1'b0;
      r_fault    <= 1'b0;
`ifdef ENC_TRACK_VEL_EN
      r_win_cnt  <= '0;
      r_vel_acc  <= '0;
      r_vel      <= '0;
      r_vel_vld  <= 1'b0;
`endif
    end else begin
      r_abs_vld  <= 1'b0;
      r_jump_err <= 1'b0;
`ifdef ENC_TRACK_VEL_EN
      r_vel_vld  <= 1'b0;
`endif
      if (clr) begin
        r_state   <= IDLE;
        r_err_cnt <= '0;
        r_fault   <= 1'b0;
`ifdef ENC_TRACK_VEL_EN
        r_win_cnt <= '0;
        r_vel_acc <= '0;
`endif
      end else if (pos_vld) begin
        case (r_state)
          IDLE: begin
            r_abs_pos  <= {{TURN_W{1'b0}}, pos_in};
            r_last_pos <= pos_in;
            r_delta    <= '0;
            r_abs_vld  <= 1'b1;
            r_state    <= TRACK;
          end
          TRACK: begin
            if (w_accept) begin
              r_abs_pos  <= r_abs_pos + AP_W'(sext_step(SEXT_W'(w_step), ST_W));
              r_last_pos <= pos_in;
              r_delta    <= w_step;
              r_abs_vld  <= 1'b1;
              r_err_cnt  <= '0;
`ifdef ENC_TRACK_VEL_EN
              r_win_cnt  <= r_win_cnt + AVG_LOG'(1);
              if (&r_win_cnt) begin
                r_vel     <= r_vel_acc + VEL_W'(sext_step(SEXT_W'(w_step), ST_W));
                r_vel_vld <= 1'b1;
                r_vel_acc <= '0;
              end else begin
                r_vel_acc <= r_vel_acc + VEL_W'(sext_step(SEXT_W'(w_step), ST_W));
              end
`endif
            end else begin
              r_jump_err <= 1'b1;
              r_err_cnt  <= r_err_cnt + 4'd1;
              if (r_err_cnt + 4'd1 == 4'(MAX_ERR)) begin
                r_state <= FAULT;
                r_fault <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign abs_pos  = r_abs_pos;
  assign abs_vld  = r_abs_vld;
  assign delta    = r_delta;
  assign jump_err = r_jump_err;
  assign fault    = r_fault;
`ifdef ENC_TRACK_VEL_EN
  assign vel      = r_vel;
  assign vel_vld  = r_vel_vld;
`endif

endmodule

// File: tb/tb_enc_track.sv
// Scoreboard bench for enc_track: stimulus pushes expected frames, a monitor pops and compares.
module tb_enc_track;

  localparam int ST_W  = 17;
  localparam int AP_W  = 33;
  localparam int VEL_W = 19;

  logic             enc_clk = 1'b0;
  logic             rst;
  logic             pos_vld;
  logic [ST_W-1:0]  pos_in;
  logic             clr;
  logic [AP_W-1:0]  abs_pos;
  logic             abs_vld;
  logic [ST_W-1:0]  delta;
  logic             jump_err;
  logic             fault;
`ifdef ENC_TRACK_VEL_EN
  logic [VEL_W-1:0] vel;
  logic             vel_vld;
`endif

  enc_track dut (
    .enc_clk  (enc_clk),
    .rst      (rst),
    .pos_vld  (pos_vld),
    .pos_in   (pos_in),
    .clr      (clr),
    .abs_pos  (abs_pos),
    .abs_vld  (abs_vld),
    .delta    (delta),
    .jump_err (jump_err),
    .fault    (fault)
`ifdef ENC_TRACK_VEL_EN
    ,
    .vel      (vel),
    .vel_vld  (vel_vld)
`endif
  );

  always #5 enc_clk = ~enc_clk;

  typedef struct {
    logic             absVld;
    logic             jumpErr;
    logic [AP_W-1:0]  absPos;
    logic [ST_W-1:0]  delta;
    logic             fault;
    logic             velVld;
    logic [VEL_W-1:0] vel;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge enc_clk) begin : monitor
    exp_t e;
    if (abs_vld === 1'b1 || jump_err === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_output: abs_vld=%0b jump_err=%0b abs_pos=0x%0h, expected no output",
                 abs_vld, jump_err, abs_pos);
      end else begin
        e = expQ.pop_front();
        checkOutput("abs_vld",  64'(abs_vld),  64'(e.absVld));
        checkOutput("jump_err", 64'(jump_err), 64'(e.jumpErr));
        checkOutput("abs_pos",  64'(abs_pos),  64'(e.absPos));
        checkOutput("delta",    64'(delta),    64'(e.delta));
        checkOutput("fault",    64'(fault),    64'(e.fault));
`ifdef ENC_TRACK_VEL_EN
        checkOutput("vel_vld",  64'(vel_vld),  64'(e.velVld));
        if (e.velVld) checkOutput("vel", 64'(vel), 64'(e.vel));
`endif
      end
    end
  end

  task automatic applyStimulus(input logic vld, input logic [ST_W-1:0] pos, input logic doClr,
                               input logic expOut, input exp_t e);
    @(posedge enc_clk);
    #1;
    pos_vld = vld;
    pos_in  = pos;
    clr     = doClr;
    if (expOut) expQ.push_back(e);
  endtask

  task automatic frame(input logic [ST_W-1:0] pos, input logic [AP_W-1:0] expAbs,
                       input logic [ST_W-1:0] expDelta, input logic expJump = 1'b0,
                       input logic expFault = 1'b0, input logic expVelVld = 1'b0,
                       input logic [VEL_W-1:0] expVel = '0);
    exp_t e;
    e.absVld  = !expJump;
    e.jumpErr = expJump;
    e.absPos  = expAbs;
    e.delta   = expDelta;
    e.fault   = expFault;
    e.velVld  = expVelVld;
    e.vel     = expVel;
    applyStimulus(1'b1, pos, 1'b0, 1'b1, e);
  endtask

  task automatic frameDropped(input logic [ST_W-1:0] pos, input logic withClr);
    exp_t e;
    e = '{default: '0};
    applyStimulus(1'b1, pos, withClr, 1'b0, e);
  endtask

  task automatic clearReq();
    exp_t e;
    e = '{default: '0};
    applyStimulus(1'b0, '0, 1'b1, 1'b0, e);
  endtask

  task automatic idle();
    @(posedge enc_clk);
    #1;
    pos_vld = 1'b0;
    clr     = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    pos_vld = 1'b0;
    pos_in  = '0;
    clr     = 1'b0;
    repeat (3) @(posedge enc_clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_abs_pos",  64'(abs_pos),  64'd0);
    checkOutput("reset_abs_vld",  64'(abs_vld),  64'd0);
    checkOutput("reset_delta",    64'(delta),    64'd0);
    checkOutput("reset_jump_err", 64'(jump_err), 64'd0);
    checkOutput("reset_fault",    64'(fault),    64'd0);
`ifdef ENC_TRACK_VEL_EN
    checkOutput("reset_vel",      64'(vel),      64'd0);
    checkOutput("reset_vel_vld",  64'(vel_vld),  64'd0);
`endif

    $display("[TB] seed from reset");
    frame(17'd100, 33'd100, 17'd0);
    clearReq();

    $display("[TB] forward wrap across turn boundary");
    frame(17'd131070, 33'd131070, 17'd0);
    frame(17'd5, 33'd131077, 17'd7);
    clearReq();

    $display("[TB] backward wrap below zero");
    frame(17'd3, 33'd3, 17'd0);
    frame(17'd131071, 33'h1_FFFF_FFFF, 17'h1FFFC);
    clearReq();

    $display("[TB] repeated jumps latch fault");
    frame(17'd1000, 33'd1000, 17'd0);
    frame(17'd5000, 33'd1000, 17'd0, 1'b1, 1'b0);
    frame(17'd5000, 33'd1000, 17'd0, 1'b1, 1'b0);
    frame(17'd5000, 33'd1000, 17'd0, 1'b1, 1'b1);
    frameDropped(17'd1010, 1'b0);
    idle();
    checkOutput("fault_latched",   64'(fault),   64'd1);
    checkOutput("fault_abs_held",  64'(abs_pos), 64'd1000);
    clearReq();
    idle();
    checkOutput("fault_cleared",   64'(fault),   64'd0);
    frame(17'd7, 33'd7, 17'd0);

    $display("[TB] step limits and error counter reset");
    frame(17'd20, 33'd20, 17'd13);
    frame(17'd1044, 33'd1044, 17'd1024);
    frame(17'd2069, 33'd1044, 17'd1024, 1'b1, 1'b0);
    frame(17'd20, 33'd20, 17'h1FC00);
    frame(17'd2069, 33'd20, 17'h1FC00, 1'b1, 1'b0);
    frame(17'd2069, 33'd20, 17'h1FC00, 1'b1, 1'b0);
    frame(17'd21, 33'd21, 17'd1, 1'b0, 1'b0, 1'b1, 19'd14);
    frame(17'd65557, 33'd21, 17'd1, 1'b1, 1'b0);
    frame(17'd22, 33'd22, 17'd1);

    $display("[TB] clr collides with a frame");
    frameDropped(17'd50, 1'b1);
    frame(17'd60, 33'd60, 17'd0);
    clearReq();

    $display("[TB] velocity window");
    frame(17'd0, 33'd0, 17'd0);
    frame(17'd10, 33'd10, 17'd10);
    frame(17'd20, 33'd20, 17'd10);
    frame(17'd30, 33'd30, 17'd10);
    frame(17'd40, 33'd40, 17'd10, 1'b0, 1'b0, 1'b1, 19'd40);
    idle();

    $display("[TB] reset during operation");
    @(posedge enc_clk);
    #1;
    rst     = 1'b1;
    pos_vld = 1'b1;
    pos_in  = 17'd500;
    @(posedge enc_clk);
    #1;
    rst     = 1'b0;
    pos_vld = 1'b0;
    checkOutput("midrst_abs_pos", 64'(abs_pos), 64'd0);
    checkOutput("midrst_delta",   64'(delta),   64'd0);
    frame(17'd100, 33'd100, 17'd0);
    idle();

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge enc_clk);
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
